instr_prefetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 46 ++++
 rtl/instr_prefetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_prefetch_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    LAST
  } fetch_state_t;

  localparam int DEF_ADDR_WIDTH  = 24;
  localparam int DEF_INSTR_WIDTH = 64;

  // FIFO entry layout at the default widths; the top re-declares it at its own widths.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]  pc;
    logic [DEF_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic int calc_beats(input int instr_width, input int mem_data_width);
    return instr_width / mem_data_width;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy output; head is a combinational read.
module fetch_fifo #(
  parameter int WIDTH = 88,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is cleared only by reset so the empty head reads as zero; flush just moves pointers.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch_unit.sv
// Instruction prefetcher: assembles wide instructions from narrow memory beats into a FIFO.
// Optional feature macro: FETCH_REDIRECT_EN (redirect/flush port active when defined).
module instr_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 24,
  parameter int                    INSTR_WIDTH    = 64,
  parameter int                    MEM_DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_en_i,
  input  logic                      redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]     redirect_pc_i,
  output logic                      mem_req_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata_i,
  output logic                      instr_valid_o,
  output logic [INSTR_WIDTH-1:0]    instr_o,
  output logic [ADDR_WIDTH-1:0]     instr_pc_o,
  input  logic                      instr_ready_i,
  output logic [ADDR_WIDTH-1:0]     pc_o,
  output logic                      busy_o
);

  localparam int BEATS = calc_beats(INSTR_WIDTH, MEM_DATA_WIDTH);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ADDR_WIDTH + INSTR_WIDTH;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [OCC_W-1:0] DEPTH_L   = OCC_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_t           state;
  logic [CNT_W-1:0]       beat_cnt;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  pc_start;
  logic [INSTR_WIDTH-1:0] asm_q;
  logic [INSTR_WIDTH-1:0] asm_next;
  logic                   req_q;
  logic                   busy_q;
  logic                   flush;
  logic                   push;
  logic                   pop;
  logic [OCC_W-1:0]       occ;
  entry_t                 push_entry;
  entry_t                 head_entry;

`ifdef FETCH_REDIRECT_EN
  assign flush = redirect_valid_i;
`else
  assign flush = 1'b0;
  logic unused_redirect;
  assign unused_redirect = ^{redirect_valid_i, redirect_pc_i};
`endif

  // Beats shift in from the LSB end, so the first beat ends up in the MSBs.
  assign asm_next = (asm_q << MEM_DATA_WIDTH) | INSTR_WIDTH'(mem_rdata_i);

  assign push             = (state == LAST);
  assign pop              = instr_valid_o && instr_ready_i;
  assign push_entry.pc    = pc_start;
  assign push_entry.instr = asm_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      pc       <= RESET_PC;
      pc_start <= '0;
      asm_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
    end
`ifdef FETCH_REDIRECT_EN
    else if (redirect_valid_i) begin
      state    <= IDLE;
      beat_cnt <= '0;
      pc       <= redirect_pc_i;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
    end
`endif
    else begin
      case (state)
        IDLE: begin
          if (fetch_en_i && (occ < DEPTH_L)) begin
            state    <= ISSUE;
            pc_start <= pc;
            beat_cnt <= '0;
            req_q    <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ISSUE: begin
          pc <= pc + ADDR_WIDTH'(1);
          // Beat 0 has no returning data; later beats capture the previous request's data.
          if (beat_cnt != '0) asm_q <= asm_next;
          if (beat_cnt == LAST_BEAT) begin
            state <= LAST;
            req_q <= 1'b0;
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        LAST: begin
          // Occupancy before this cycle's push and pop, so the check is conservative.
          if (fetch_en_i && ((occ + OCC_W'(1)) < DEPTH_L)) begin
            state    <= ISSUE;
            pc_start <= pc;
            beat_cnt <= '0;
            req_q    <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          req_q  <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (occ)
  );

  assign instr_valid_o = (occ != '0);
  assign instr_o       = head_entry.instr;
  assign instr_pc_o    = head_entry.pc;
  assign mem_req_o     = req_q;
  assign mem_addr_o    = pc;
  assign pc_o          = pc;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Self-checking bench for instr_prefetch_unit: per-cycle behavioural model plus directed literal checks.
module tb_instr_prefetch_unit;

  localparam int AW    = 24;
  localparam int IW    = 64;
  localparam int MW    = 8;
  localparam int DEPTH = 4;
  localparam int BEATS = IW / MW;

`ifdef FETCH_REDIRECT_EN
  localparam bit REDIR_EN = 1'b1;
`else
  localparam bit REDIR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          instr_ready = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [MW-1:0] mem_rdata;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] pc;
  logic          busy;

  logic          w_fetch_en = 1'b0;
  logic          w_ready = 1'b0;
  logic          w_req;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_rdata;
  logic          w_valid;
  logic [IW-1:0] w_instr;
  logic [AW-1:0] w_instr_pc;
  logic [AW-1:0] w_pc;
  logic          w_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_prefetch_unit #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .MEM_DATA_WIDTH(MW), .FIFO_DEPTH(DEPTH), .RESET_PC(24'h0)
  ) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en),
    .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(instr_ready), .pc_o(pc), .busy_o(busy)
  );

  instr_prefetch_unit #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .MEM_DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .RESET_PC(24'hFFFFFC)
  ) dut_wrap (
    .clk(clk), .rst(rst), .fetch_en_i(w_fetch_en),
    .redirect_valid_i(1'b0), .redirect_pc_i(24'h0),
    .mem_req_o(w_req), .mem_addr_o(w_addr), .mem_rdata_i(w_rdata),
    .instr_valid_o(w_valid), .instr_o(w_instr), .instr_pc_o(w_instr_pc),
    .instr_ready_i(w_ready), .pc_o(w_pc), .busy_o(w_busy)
  );

  // One-cycle-latency memories: data is a function of the address; idle cycles return junk.
  always @(posedge clk) begin
    mem_rdata <= mem_req ? mem_addr[7:0] : 8'hEE;
    w_rdata   <= w_req ? w_addr[15:0] : 16'hEEEE;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  ent_t          mq[$];
  bit            m_started = 1'b0;
  bit            m_active = 1'b0;
  int            m_issued = 0;
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_start = '0;

  function automatic logic [IW-1:0] build(input logic [AW-1:0] s);
    logic [IW-1:0] r = '0;
    logic [AW-1:0] a;
    for (int k = 0; k < BEATS; k++) begin
      a = s + AW'(k);
      r = {r[IW-MW-1:0], a[7:0]};
    end
    return r;
  endfunction

  task automatic model_step();
    int   occ;
    bit   do_pop;
    bit   do_push;
    ent_t pe;
    if (rst) begin
      mq.delete();
      m_active  = 1'b0;
      m_issued  = 0;
      m_pc      = '0;
      m_started = 1'b1;
    end else if (REDIR_EN && redirect_valid) begin
      mq.delete();
      m_active = 1'b0;
      m_issued = 0;
      m_pc     = redirect_pc;
    end else begin
      occ     = mq.size();
      do_pop  = (occ > 0) && instr_ready;
      do_push = 1'b0;
      if (!m_active) begin
        if (fetch_en && occ < DEPTH) begin
          m_active = 1'b1;
          m_issued = 0;
          m_start  = m_pc;
        end
      end else if (m_issued < BEATS) begin
        m_issued++;
        m_pc = m_pc + AW'(1);
      end else begin
        do_push  = 1'b1;
        pe.pc    = m_start;
        pe.instr = build(m_start);
        if (fetch_en && occ + 1 < DEPTH) begin
          m_issued = 0;
          m_start  = m_pc;
        end else begin
          m_active = 1'b0;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(pe);
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (m_started) begin
      check("mem_req", mem_req, m_active && (m_issued < BEATS));
      check("busy", busy, m_active);
      check("pc", pc, m_pc);
      check("mem_addr", mem_addr, m_pc);
      check("instr_valid", instr_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        check("instr", instr, mq[0].instr);
        check("instr_pc", instr_pc, mq[0].pc);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done = 1'b0;
    @(negedge clk);
    fetch_en    = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (!busy && !instr_valid) done = 1'b1;
    end
    check("drain_done", done, 1'b1);
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  initial begin
    int            req_cnt;
    bit            seen;
    int            n;
    logic [AW-1:0] addrs [8];
    logic [AW-1:0] exp_addrs [8];

    exp_addrs = '{24'hFFFFFC, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFF,
                  24'h000000, 24'h000001, 24'h000002, 24'h000003};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_pc", pc, 24'h0);
    check("rst_instr", instr, 64'h0);
    check("rst_instr_pc", instr_pc, 24'h0);
    rst      = 1'b0;
    fetch_en = 1'b1;

    // First-instruction latency, then fill the FIFO with no consumer
    req_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mem_req) req_cnt++;
      if (i == 8) check("lat_not_yet", instr_valid, 1'b0);
      if (i == 9) begin
        check("lat_valid", instr_valid, 1'b1);
        check("first_instr", instr, 64'h0001020304050607);
        check("first_pc", instr_pc, 24'h0);
      end
    end
    check("fill_req_count", req_cnt, 32);
    check("full_busy", busy, 1'b0);
    check("full_req", mem_req, 1'b0);

    // Pop one entry: second instruction at head, fetch restarts
    @(negedge clk);
    instr_ready = 1'b1;
    tick();
    check("second_instr", instr, 64'h08090A0B0C0D0E0F);
    check("second_pc", instr_pc, 24'h8);
    @(negedge clk);
    instr_ready = 1'b0;
    tick();
    check("restart_busy", busy, 1'b1);
    check("restart_req", mem_req, 1'b1);
    check("restart_addr", mem_addr, 24'h20);

    drain();

    // Redirect during beat 3 of the second instruction (one entry already queued)
    fetch_en = 1'b1;
    repeat (13) tick();
    check("pre_redir_addr", mem_addr, 24'h33);
    check("pre_redir_valid", instr_valid, 1'b1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 24'h100;
    tick();
`ifdef FETCH_REDIRECT_EN
    check("redir_valid", instr_valid, 1'b0);
    check("redir_busy", busy, 1'b0);
    check("redir_pc", pc, 24'h100);
`else
    check("noredir_valid", instr_valid, 1'b1);
    check("noredir_busy", busy, 1'b1);
    check("noredir_pc", pc, 24'h34);
`endif
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
`ifdef FETCH_REDIRECT_EN
    tick();
    check("redir_req", mem_req, 1'b1);
    check("redir_addr", mem_addr, 24'h100);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (instr_valid) seen = 1'b1;
    end
    check("redir_seen", seen, 1'b1);
    check("redir_instr", instr, 64'h0001020304050607);
    check("redir_instr_pc", instr_pc, 24'h100);
`endif

    drain();

    // Reset while in LAST: in-flight instruction must be dropped
    fetch_en = 1'b1;
    repeat (9) tick();
    check("in_last_busy", busy, 1'b1);
    check("in_last_req", mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("rst_last_valid", instr_valid, 1'b0);
    check("rst_last_pc", pc, 24'h0);
    check("rst_last_busy", busy, 1'b0);
    check("rst_last_instr", instr, 64'h0);
    @(negedge clk);
    rst      = 1'b0;
    fetch_en = 1'b0;
    repeat (15) tick();
    check("rst_last_no_push", instr_valid, 1'b0);

    // Address wrap with 16-bit beats starting at 0xFFFFFC
    @(negedge clk);
    w_fetch_en = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      tick();
      if (w_req) begin
        addrs[n] = w_addr;
        n++;
      end
    end
    check("wrap_req_count", n, 8);
    for (int k = 0; k < 8; k++) check("wrap_addr", addrs[k], exp_addrs[k]);
    repeat (2) tick();
    check("wrap_valid", w_valid, 1'b1);
    check("wrap_instr0", w_instr, 64'hFFFCFFFDFFFEFFFF);
    check("wrap_pc0", w_instr_pc, 24'hFFFFFC);
    @(negedge clk);
    w_ready = 1'b1;
    tick();
    check("wrap_instr1", w_instr, 64'h0000000100020003);
    check("wrap_pc1", w_instr_pc, 24'h000000);
    @(negedge clk);
    w_ready    = 1'b0;
    w_fetch_en = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
